// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Registered branch resolver for the MIPS pipeline. It compares two operands
//   under a 4-bit branch opcode. One cycle after a request is accepted, it
//   presents the taken decision, a mispredict flag against the supplied
//   prediction, and the request tag. A single-entry output register gives
//   valid/ready backpressure with full 1-per-cycle throughput.
//
//   Optional build macro: BRANCH_RESOLVE_PERF_CNT_EN
//     defined   -> saturating counters of accepted branches / mispredicts
//     undefined -> cnt_branch / cnt_mispred tied to zero, no counter flops
//
// Parameters
//   WIDTH  operand width (>= 2)
//   TAG_W  opaque tag width
//   CNT_W  performance counter width
//
// Ports
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   in_valid       request valid
//   in_ready       request can be accepted (!out_valid || out_ready)
//   in_d1, in_d2   operands
//   in_op          branch opcode (0 NONE .. 11 ALWAYS, 12-15 treated as NONE)
//   in_pred        predicted-taken bit
//   in_tag         request tag
//   flush          drop held result and any request presented this cycle
//   out_valid      result valid
//   out_ready      consumer accepts result
//   out_taken      resolved direction
//   out_mispredict resolved direction differs from prediction (non-NONE ops)
//   out_tag        tag of the result
//   cnt_branch     accepted non-NONE results
//   cnt_mispred    accepted mispredicted results
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d1,
  input  logic [WIDTH-1:0] in_d2,
  input  logic [3:0]       in_op,
  input  logic             in_pred,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispred
);

  localparam logic [3:0] OP_NONE   = 4'd0;
  localparam logic [3:0] OP_EQ     = 4'd1;
  localparam logic [3:0] OP_NE     = 4'd2;
  localparam logic [3:0] OP_LEZ    = 4'd3;
  localparam logic [3:0] OP_GTZ    = 4'd4;
  localparam logic [3:0] OP_LTZ    = 4'd5;
  localparam logic [3:0] OP_GEZ    = 4'd6;
  localparam logic [3:0] OP_LT     = 4'd7;
  localparam logic [3:0] OP_GE     = 4'd8;
  localparam logic [3:0] OP_LTU    = 4'd9;
  localparam logic [3:0] OP_GEU    = 4'd10;
  localparam logic [3:0] OP_ALWAYS = 4'd11;

  // ---- Stage 0: combinational compare on the incoming request ----
  logic signed [WIDTH-1:0] d1_s;
  logic signed [WIDTH-1:0] d2_s;
  logic                    taken_c;
  logic                    nonnone_c;
  logic                    mispred_c;
  logic                    load;

  assign d1_s = in_d1;
  assign d2_s = in_d2;

  always_comb begin
    taken_c   = 1'b0;
    nonnone_c = 1'b1;
    case (in_op)
      OP_EQ:     taken_c = (in_d1 == in_d2);
      OP_NE:     taken_c = (in_d1 != in_d2);
      OP_LEZ:    taken_c = (d1_s <= 0);
      OP_GTZ:    taken_c = (d1_s > 0);
      OP_LTZ:    taken_c = d1_s[WIDTH-1];
      OP_GEZ:    taken_c = !d1_s[WIDTH-1];
      OP_LT:     taken_c = (d1_s < d2_s);
      OP_GE:     taken_c = (d1_s >= d2_s);
      OP_LTU:    taken_c = (in_d1 < in_d2);
      OP_GEU:    taken_c = (in_d1 >= in_d2);
      OP_ALWAYS: taken_c = 1'b1;
      default:   nonnone_c = 1'b0;  // NONE and reserved 12-15
    endcase
  end

  // NONE/reserved never mispredict, whatever the prediction bit says.
  assign mispred_c = nonnone_c && (taken_c != in_pred);

  // ---- Stage 1: single-entry output register ----
  logic             out_valid_q, out_valid_d;
  logic             taken_q;
  logic             mispred_q;
  logic [TAG_W-1:0] tag_q;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (load)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      mispred_q   <= 1'b0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        taken_q   <= taken_c;
        mispred_q <= mispred_c;
        tag_q     <= in_tag;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = taken_q;
  assign out_mispredict = mispred_q;
  assign out_tag        = tag_q;

`ifdef BRANCH_RESOLVE_PERF_CNT_EN
  // ---- Counters: sample results as they leave the output register ----
  logic             nonnone_q;
  logic             fire;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign fire = out_valid_q && out_ready && !flush && nonnone_q;

  always_comb begin
    cnt_branch_d  = cnt_branch_q;
    cnt_mispred_d = cnt_mispred_q;
    if (fire) begin
      cnt_branch_d = sat_inc(cnt_branch_q);
      if (mispred_q) cnt_mispred_d = sat_inc(cnt_mispred_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nonnone_q     <= 1'b0;
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      if (load) nonnone_q <= nonnone_c;
      cnt_branch_q  <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign cnt_branch  = cnt_branch_q;
  assign cnt_mispred = cnt_mispred_q;
`else
  assign cnt_branch  = '0;
  assign cnt_mispred = '0;
`endif

endmodule
